writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: buffers retire requests in a DEPTH-entry FIFO and retires
// them in order, producing one-cycle pulses for PC load, register-file write
// and a generic done. Entries flagged with wselector[3] first offer their low
// data byte on a valid/ready out port and retire only once it is accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready = !full)
//   wselector                bit3 out, bit2 pc update, bit1 reg write, bit0 fmode
//   pc, data, rd             request payload
//   done                     one-cycle retire pulse
//   pcenable / next_pc       one-cycle PC-load pulse and target
//   wenable / fmode / wreg / wdata
//                            one-cycle register write pulse, file select, address, data
//   out_valid / out_ready / out_data
//                            out byte handshake, out_data = data[7:0]
module writeback_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      wselector,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data,
  input  logic [REGW-1:0] rd,
  output logic            done,
  output logic            pcenable,
  output logic [XLEN-1:0] next_pc,
  output logic            wenable,
  output logic            fmode,
  output logic [REGW-1:0] wreg,
  output logic [XLEN-1:0] wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {
    StIssue,
    StOutWait
  } state_e;

  // FIFO storage
  logic [3:0]      wsel_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [REGW-1:0] rd_mem   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  state_e state_q, state_d;

  logic full, empty, push, pop, out_load;

  logic [3:0]      head_wsel;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_data;
  logic [REGW-1:0] head_rd;

  logic            head_wr;

  logic            done_q, pcenable_q, wenable_q, fmode_q, out_valid_q;
  logic [XLEN-1:0] next_pc_q, wdata_q;
  logic [REGW-1:0] wreg_q;
  logic [7:0]      out_data_q;

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  // No bypass: a full queue refuses pushes even when it pops this cycle.
  assign push     = in_valid && !full;

  assign head_wsel = wsel_mem[rd_ptr_q];
  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign head_rd   = rd_mem[rd_ptr_q];

  // Writes to integer x0 are suppressed; FP f0 is a real register.
  assign head_wr = head_wsel[1] && !((head_rd == '0) && !head_wsel[0]);

  // Issue FSM: decides pops and out-byte loads from the current head.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      StIssue: begin
        if (!empty) begin
          if (head_wsel[3]) begin
            out_load = 1'b1;
            state_d  = StOutWait;
          end else begin
            pop = 1'b1;
          end
        end
      end
      StOutWait: begin
        if (out_ready) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIssue;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      wsel_mem[wr_ptr_q] <= wselector;
      pc_mem[wr_ptr_q]   <= pc;
      data_mem[wr_ptr_q] <= data;
      rd_mem[wr_ptr_q]   <= rd;
    end
  end

  // Registered retire outputs: pulses last one cycle, payloads hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b0;
      pcenable_q  <= 1'b0;
      wenable_q   <= 1'b0;
      fmode_q     <= 1'b0;
      next_pc_q   <= '0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q     <= pop;
      pcenable_q <= pop && head_wsel[2];
      wenable_q  <= pop && head_wr;
      if (pop && head_wsel[2]) begin
        next_pc_q <= head_pc;
      end
      if (pop && head_wr) begin
        fmode_q <= head_wsel[0];
        wreg_q  <= head_rd;
        wdata_q <= head_data;
      end
      if (out_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head_data[7:0];
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign done      = done_q;
  assign pcenable  = pcenable_q;
  assign next_pc   = next_pc_q;
  assign wenable   = wenable_q;
  assign fmode     = fmode_q;
  assign wreg      = wreg_q;
  assign wdata     = wdata_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
